apb_wait_slave: RTL and testbench

APB3 responder with a word-addressed register bank, programmable wait states and an error response. It is the completer-side counterpart to the APB master in the subsystem. It plugs into the master's select, enable, write, address and data nets, and adds `Pslverr` for out-of-range accesses. It lets the master's wait-state and error handling be exercised against a slower, stricter peripheral.

---
 rtl/apb_wait_slave.sv | 126 ++++++++++++
 tb/tb_apb_wait_slave.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_wait_slave.sv
// APB3 completer: word register bank, programmable wait states, Pslverr on out-of-range access.
// Latency: 2 + WAIT_CYCLES clocks from setup to completion; Pready held low while the wait counter runs.
// Backpressure: the bus stalls on Pready=0. Optional macro APB_SLV_PSTRB_EN adds Pstrb byte-lane writes.
module apb_wait_slave #(
    parameter int ADD_WIDTH   = 8,
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 Pclk,
    input  logic                 Presetn,
    input  logic                 Psel,
    input  logic                 Penable,
    input  logic                 Pwrite,
    input  logic [ADD_WIDTH-1:0] Paddr,
    input  logic [WIDTH-1:0]     Pwdata,
`ifdef APB_SLV_PSTRB_EN
    input  logic [WIDTH/8-1:0]   Pstrb,
`endif
    output logic [WIDTH-1:0]     Prdata,
    output logic                 Pready,
    output logic                 Pslverr
);
    localparam int          IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          NB      = WIDTH / 8;
    localparam logic [31:0] DEPTH_U = 32'(DEPTH);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    typedef struct packed {
        logic                 write;
        logic [ADD_WIDTH-1:0] addr;
    } req_t;

    state_t           state, state_nxt;
    req_t             req, req_nxt;
    logic [3:0]       cnt, cnt_nxt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             start, in_access, done, in_range;
    logic [IDX_W-1:0] idx;
    logic [NB-1:0]    lane_en;

    // SETUP is the first access-phase cycle after the address was captured,
    // so a zero-wait transfer can complete there and keep the 2-clock minimum.
    assign start     = Psel && !Penable;
    assign in_access = ((state == SETUP) || (state == ACCESS)) && Psel && Penable;
    assign done      = in_access && (cnt == 4'd0);
    assign in_range  = (32'(req.addr) < DEPTH_U);
    assign idx       = req.addr[IDX_W-1:0];

`ifdef APB_SLV_PSTRB_EN
    assign lane_en = Pstrb;
`else
    assign lane_en = '1;
`endif

    always_ff @(posedge Pclk or negedge Presetn) begin
        if (!Presetn) begin
            state <= IDLE;
            cnt   <= 4'd0;
            req   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            req   <= req_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        req_nxt   = req;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt     = SETUP;
                    cnt_nxt       = 4'(WAIT_CYCLES);
                    req_nxt.write = Pwrite;
                    req_nxt.addr  = Paddr;
                end
            end
            SETUP, ACCESS: begin
                if (!in_access) begin
                    // Psel/Penable dropped before completion: abandon silently.
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                end else if (cnt != 4'd0) begin
                    state_nxt = ACCESS;
                    cnt_nxt   = cnt - 4'd1;
                end else begin
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_comb begin
        Pready  = done;
        Pslverr = done && !in_range;
        Prdata  = '0;
        if (done && !req.write && in_range) begin
            Prdata = mem[idx];
        end
    end

    // Write data and strobes are taken live at the completing edge.
    always_ff @(posedge Pclk or negedge Presetn) begin
        if (!Presetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (done && req.write && in_range) begin
            for (int b = 0; b < NB; b++) begin
                if (lane_en[b]) begin
                    mem[idx][8*b +: 8] <= Pwdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_wait_slave.sv
// Directed bench for apb_wait_slave: dut0 runs 2 wait states, dut1 runs zero wait states.
module tb_apb_wait_slave;
    logic        Pclk = 1'b0;
    logic        Presetn;
    logic        Psel0, Psel1, Penable, Pwrite;
    logic [7:0]  Paddr;
    logic [31:0] Pwdata;
`ifdef APB_SLV_PSTRB_EN
    logic [3:0]  Pstrb;
`endif
    logic [31:0] Prdata0, Prdata1;
    logic        Pready0, Pready1, Pslverr0, Pslverr1;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_mem [64];

    always #5 Pclk = ~Pclk;

    apb_wait_slave #(.ADD_WIDTH(8), .WIDTH(32), .DEPTH(64), .WAIT_CYCLES(2)) dut0 (
        .Pclk(Pclk), .Presetn(Presetn), .Psel(Psel0), .Penable(Penable), .Pwrite(Pwrite),
        .Paddr(Paddr), .Pwdata(Pwdata),
`ifdef APB_SLV_PSTRB_EN
        .Pstrb(Pstrb),
`endif
        .Prdata(Prdata0), .Pready(Pready0), .Pslverr(Pslverr0)
    );

    apb_wait_slave #(.ADD_WIDTH(8), .WIDTH(32), .DEPTH(64), .WAIT_CYCLES(0)) dut1 (
        .Pclk(Pclk), .Presetn(Presetn), .Psel(Psel1), .Penable(Penable), .Pwrite(Pwrite),
        .Paddr(Paddr), .Pwdata(Pwdata),
`ifdef APB_SLV_PSTRB_EN
        .Pstrb(Pstrb),
`endif
        .Prdata(Prdata1), .Pready(Pready1), .Pslverr(Pslverr1)
    );

    function automatic logic rdy(input bit d1);
        return d1 ? Pready1 : Pready0;
    endfunction

    function automatic logic serr(input bit d1);
        return d1 ? Pslverr1 : Pslverr0;
    endfunction

    function automatic logic [31:0] rdat(input bit d1);
        return d1 ? Prdata1 : Prdata0;
    endfunction

    // Drives one full APB transfer; waits counts access cycles with Pready low (capped at 20),
    // stale flags any non-ready cycle showing nonzero Prdata or Pslverr.
    task automatic xfer(input bit d1, input bit wr, input logic [7:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int waits, output bit stale);
        rd = 32'h0; er = 1'b0; waits = 0; stale = 1'b0;
        @(negedge Pclk);
        Psel0 = !d1; Psel1 = d1; Penable = 1'b0; Pwrite = wr; Paddr = a; Pwdata = wd;
        @(negedge Pclk);
        Penable = 1'b1;
        #1;
        while (rdy(d1) !== 1'b1 && waits < 20) begin
            if (rdat(d1) !== 32'h0 || serr(d1) !== 1'b0) stale = 1'b1;
            waits++;
            @(negedge Pclk);
            #1;
        end
        rd = rdat(d1);
        er = serr(d1);
        @(posedge Pclk);
        #1;
        Psel0 = 1'b0; Psel1 = 1'b0; Penable = 1'b0;
    endtask

    task automatic test_reset();
        Presetn = 1'b0; Psel0 = 1'b0; Psel1 = 1'b0; Penable = 1'b0; Pwrite = 1'b0;
        Paddr = 8'h0; Pwdata = 32'h0;
`ifdef APB_SLV_PSTRB_EN
        Pstrb = 4'hF;
`endif
        for (int i = 0; i < 64; i++) exp_mem[i] = 32'h0;
        #12;
        total++;
        if ({Pready0, Pslverr0, Pready1, Pslverr1} !== 4'b0000) begin
            bad++; $display("FAIL reset_flags got=%b want=0000", {Pready0, Pslverr0, Pready1, Pslverr1});
        end
        total++;
        if (Prdata0 !== 32'h0 || Prdata1 !== 32'h0) begin
            bad++; $display("FAIL reset_prdata got=%h/%h want=0", Prdata0, Prdata1);
        end
        @(negedge Pclk);
        Presetn = 1'b1;
    endtask

    task automatic test_zero_wait();
        logic [31:0] rd; logic er; int w; bit st;
        xfer(1'b1, 1'b0, 8'd0, 32'h0, rd, er, w, st);
        total++;
        if (w !== 0) begin bad++; $display("FAIL zw_read_waits got=%0d want=0", w); end
        total++;
        if (rd !== 32'h0 || er !== 1'b0) begin bad++; $display("FAIL zw_read_data got=%h err=%b want=0 err=0", rd, er); end
        xfer(1'b1, 1'b1, 8'd9, 32'h0BADF00D, rd, er, w, st);
        xfer(1'b1, 1'b0, 8'd9, 32'h0, rd, er, w, st);
        total++;
        if (rd !== 32'h0BADF00D || w !== 0) begin bad++; $display("FAIL zw_wr_rd got=%h waits=%0d want=0badf00d waits=0", rd, w); end
    endtask

    task automatic test_wait_states();
        logic [31:0] rd; logic er; int w; bit st;
        xfer(1'b0, 1'b1, 8'd5, 32'hDEADBEEF, rd, er, w, st);
        exp_mem[5] = 32'hDEADBEEF;
        total++;
        if (w !== 2) begin bad++; $display("FAIL ws_write_waits got=%0d want=2", w); end
        total++;
        if (er !== 1'b0 || rd !== 32'h0 || st !== 1'b0) begin
            bad++; $display("FAIL ws_write_resp got err=%b rd=%h stale=%b want 0/0/0", er, rd, st);
        end
        xfer(1'b0, 1'b0, 8'd5, 32'h0, rd, er, w, st);
        total++;
        if (w !== 2 || st !== 1'b0) begin bad++; $display("FAIL ws_read_waits got=%0d stale=%b want=2 stale=0", w, st); end
        total++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0) begin bad++; $display("FAIL ws_read_data got=%h err=%b want=deadbeef err=0", rd, er); end
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd; logic er; int w; bit st;
        xfer(1'b0, 1'b1, 8'd63, 32'h63636363, rd, er, w, st);
        exp_mem[63] = 32'h63636363;
        total++;
        if (er !== 1'b0) begin bad++; $display("FAIL oor_addr63_err got=%b want=0", er); end
        xfer(1'b0, 1'b1, 8'd70, 32'h12345678, rd, er, w, st);
        total++;
        if (er !== 1'b1 || rd !== 32'h0 || w !== 2) begin
            bad++; $display("FAIL oor_write got err=%b rd=%h waits=%0d want 1/0/2", er, rd, w);
        end
        xfer(1'b0, 1'b0, 8'd70, 32'h0, rd, er, w, st);
        total++;
        if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL oor_read got err=%b rd=%h want 1/0", er, rd); end
        xfer(1'b0, 1'b1, 8'd64, 32'hFFFF0000, rd, er, w, st);
        total++;
        if (er !== 1'b1) begin bad++; $display("FAIL oor_addr64_err got=%b want=1", er); end
        for (int i = 0; i < 64; i++) begin
            xfer(1'b0, 1'b0, 8'(i), 32'h0, rd, er, w, st);
            total++;
            if (rd !== exp_mem[i] || er !== 1'b0) begin
                bad++; $display("FAIL sweep addr=%0d got=%h err=%b want=%h err=0", i, rd, er, exp_mem[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic er; int w; bit st;
        xfer(1'b0, 1'b1, 8'd1, 32'hA5A5A5A5, rd, er, w, st);
        exp_mem[1] = 32'hA5A5A5A5;
        xfer(1'b0, 1'b0, 8'd1, 32'h0, rd, er, w, st);
        total++;
        if (rd !== 32'hA5A5A5A5 || w !== 2) begin bad++; $display("FAIL b2b_read got=%h waits=%0d want=a5a5a5a5 waits=2", rd, w); end
        // Aborted write: Penable drops after one access cycle.
        @(negedge Pclk);
        Psel0 = 1'b1; Penable = 1'b0; Pwrite = 1'b1; Paddr = 8'd1; Pwdata = 32'h0;
        @(negedge Pclk);
        Penable = 1'b1;
        @(negedge Pclk);
        Penable = 1'b0;
        #1;
        total++;
        if (Pready0 !== 1'b0 || Pslverr0 !== 1'b0) begin
            bad++; $display("FAIL abort_flags got rdy=%b err=%b want 0/0", Pready0, Pslverr0);
        end
        @(negedge Pclk);
        Psel0 = 1'b0;
        xfer(1'b0, 1'b0, 8'd1, 32'h0, rd, er, w, st);
        total++;
        if (rd !== 32'hA5A5A5A5) begin bad++; $display("FAIL abort_read got=%h want=a5a5a5a5", rd); end
    endtask

`ifdef APB_SLV_PSTRB_EN
    task automatic test_strobe();
        logic [31:0] rd; logic er; int w; bit st;
        Pstrb = 4'hF;
        xfer(1'b0, 1'b1, 8'd2, 32'h11223344, rd, er, w, st);
        Pstrb = 4'b0101;
        xfer(1'b0, 1'b1, 8'd2, 32'hAABBCCDD, rd, er, w, st);
        Pstrb = 4'hA;
        xfer(1'b0, 1'b0, 8'd2, 32'h0, rd, er, w, st);
        total++;
        if (rd !== 32'h11BB33DD) begin bad++; $display("FAIL strobe_merge got=%h want=11bb33dd", rd); end
        Pstrb = 4'h0;
        xfer(1'b0, 1'b1, 8'd2, 32'hFFFFFFFF, rd, er, w, st);
        total++;
        if (er !== 1'b0 || w !== 2) begin bad++; $display("FAIL strobe_zero_resp got err=%b waits=%0d want 0/2", er, w); end
        Pstrb = 4'hF;
        xfer(1'b0, 1'b0, 8'd2, 32'h0, rd, er, w, st);
        total++;
        if (rd !== 32'h11BB33DD) begin bad++; $display("FAIL strobe_zero_keep got=%h want=11bb33dd", rd); end
    endtask
`endif

    task automatic test_reset_mid();
        logic [31:0] rd; logic er; int w; bit st;
        @(negedge Pclk);
        Psel0 = 1'b1; Penable = 1'b0; Pwrite = 1'b1; Paddr = 8'd3; Pwdata = 32'hFFFFFFFF;
        @(negedge Pclk);
        Penable = 1'b1;
        repeat (2) @(negedge Pclk);
        #1;
        total++;
        if (Pready0 !== 1'b1) begin bad++; $display("FAIL rmid_ready_before got=%b want=1", Pready0); end
        Presetn = 1'b0;
        #1;
        total++;
        if (Pready0 !== 1'b0 || Pslverr0 !== 1'b0 || Prdata0 !== 32'h0) begin
            bad++; $display("FAIL rmid_outputs got rdy=%b err=%b rd=%h want 0/0/0", Pready0, Pslverr0, Prdata0);
        end
        Psel0 = 1'b0; Penable = 1'b0;
        @(negedge Pclk);
        Presetn = 1'b1;
        for (int i = 0; i < 64; i++) exp_mem[i] = 32'h0;
        xfer(1'b0, 1'b0, 8'd3, 32'h0, rd, er, w, st);
        total++;
        if (rd !== 32'h0 || er !== 1'b0 || w !== 2) begin
            bad++; $display("FAIL rmid_addr3 got=%h err=%b waits=%0d want 0/0/2", rd, er, w);
        end
        xfer(1'b0, 1'b0, 8'd1, 32'h0, rd, er, w, st);
        total++;
        if (rd !== 32'h0) begin bad++; $display("FAIL rmid_mem_cleared got=%h want=0", rd); end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_out_of_range();
        test_back_to_back();
`ifdef APB_SLV_PSTRB_EN
        test_strobe();
`endif
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

endmodule
